// File: rtl/job_scheduler.sv
// Job sequencer for a weight-stationary array: optional weight load, credit-gated
// input streaming, latency tracking of in-flight beats and end-of-job drain.
module job_scheduler #(
  parameter int unsigned words     = 2,
  parameter int unsigned latency   = 6 + words,
  parameter int unsigned fifoDepth = 4,
  parameter int unsigned lenWidth  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                reuseWeights,
  input  logic                abort,
  input  logic [lenWidth-1:0] batchLength,
  input  logic                S_AXIS_TVALID,
  input  logic                S_AXIS_TLAST,
  output logic                S_AXIS_TREADY,
  input  logic                outPop,
  output logic                loadingWeights,
  output logic                validInputs,
  output logic                validOutputs,
  output logic                outLast,
  output logic                fifoFlush,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam int unsigned BeatW = $clog2(words + 1);
  localparam int unsigned CredW = $clog2(fifoDepth + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [lenWidth-1:0] in_count_q, in_count_d;
  logic [lenWidth-1:0] len_q, len_d;
  logic [CredW-1:0]    credits_q, credits_d;
  logic [latency-1:0]  vld_sr_q, vld_sr_d;
  logic [latency-1:0]  lst_sr_q, lst_sr_d;
  logic                error_q, error_d;
  logic                flush_q, flush_d;
  logic                done_q, done_d;
  logic                load_beat_c, run_beat_c, last_idx_c, kill_c;

  // Handshake decode: credits gate input acceptance so the output FIFO cannot overflow.
  assign load_beat_c    = (state_q == LOAD) && S_AXIS_TVALID;
  assign run_beat_c     = (state_q == RUN) && S_AXIS_TVALID && (credits_q != '0);
  assign last_idx_c     = (in_count_q == len_q - lenWidth'(1));
  assign S_AXIS_TREADY  = (state_q == LOAD) || ((state_q == RUN) && (credits_q != '0));
  assign loadingWeights = load_beat_c;
  assign validInputs    = run_beat_c;
  assign validOutputs   = vld_sr_q[latency-1];
  assign outLast        = lst_sr_q[latency-1];
  assign fifoFlush      = flush_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign error          = error_q;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    in_count_d = in_count_q;
    len_d      = len_q;
    credits_d  = credits_q;
    vld_sr_d   = {vld_sr_q[latency-2:0], run_beat_c};
    lst_sr_d   = {lst_sr_q[latency-2:0], run_beat_c & last_idx_c};
    error_d    = 1'b0;
    flush_d    = 1'b0;
    done_d     = 1'b0;
    kill_c     = 1'b0;

    if (run_beat_c && !outPop) begin
      credits_d = credits_q - CredW'(1);
    end else if (!run_beat_c && outPop && (credits_q != CredW'(fifoDepth))) begin
      credits_d = credits_q + CredW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (batchLength == '0) begin
            error_d = 1'b1;
          end else begin
            len_d      = batchLength;
            in_count_d = '0;
            beat_d     = '0;
            state_d    = reuseWeights ? RUN : LOAD;
          end
        end
      end
      LOAD: begin
        if (load_beat_c) begin
          if (beat_q == BeatW'(words - 1)) begin
            state_d = RUN;
            beat_d  = '0;
          end else if (S_AXIS_TLAST) begin
            error_d = 1'b1;
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      RUN: begin
        // TLAST must coincide exactly with the final beat of the batch.
        if (run_beat_c) begin
          if (S_AXIS_TLAST != last_idx_c) begin
            error_d = 1'b1;
            kill_c  = 1'b1;
          end else if (last_idx_c) begin
            state_d    = DRAIN;
            in_count_d = '0;
          end else begin
            in_count_d = in_count_q + lenWidth'(1);
          end
        end
      end
      DRAIN: begin
        if (vld_sr_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      kill_c  = 1'b1;
      error_d = 1'b0;
    end

    // Cancel: drop everything in flight and hand the full FIFO back as credit.
    if (kill_c) begin
      state_d    = IDLE;
      beat_d     = '0;
      in_count_d = '0;
      vld_sr_d   = '0;
      lst_sr_d   = '0;
      credits_d  = CredW'(fifoDepth);
      flush_d    = 1'b1;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      in_count_q <= '0;
      len_q      <= '0;
      credits_q  <= CredW'(fifoDepth);
      vld_sr_q   <= '0;
      lst_sr_q   <= '0;
      error_q    <= 1'b0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      in_count_q <= in_count_d;
      len_q      <= len_d;
      credits_q  <= credits_d;
      vld_sr_q   <= vld_sr_d;
      lst_sr_q   <= lst_sr_d;
      error_q    <= error_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_job_scheduler.sv
// Bench for job_scheduler: directed scenarios plus randomized traffic, every cycle
// compared against a timestamp/queue based model of the job rules.
module tb_job_scheduler;
  localparam int unsigned W     = 2;
  localparam int unsigned LAT   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 16;

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DRAIN = 3, M_DONE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, reuse, abort, tvalid, tlast, outpop;
  logic [LW-1:0] blen;
  logic          tready, lw_o, vi_o, vo_o, olast, flush, busy, done, err;

  job_scheduler #(.words(W), .latency(LAT), .fifoDepth(DEPTH), .lenWidth(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .reuseWeights(reuse), .abort(abort),
    .batchLength(blen), .S_AXIS_TVALID(tvalid), .S_AXIS_TLAST(tlast),
    .S_AXIS_TREADY(tready), .outPop(outpop), .loadingWeights(lw_o),
    .validInputs(vi_o), .validOutputs(vo_o), .outLast(olast), .fifoFlush(flush),
    .busy(busy), .done(done), .error(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit last;
  } res_t;

  // Model state
  int   m_mode, m_wb, m_acc, m_len, m_cred;
  bit   m_err, m_flush, m_done;
  res_t m_q[$];
  int   cyc;

  // Bookkeeping of DUT-observed events for the directed literal checks
  int n_vec, n_mis;
  int n_lw, n_done, last_at;
  int vi_cyc[$];
  int vo_cyc[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_wb = 0; m_acc = 0; m_len = 0; m_cred = DEPTH;
    m_err = 1'b0; m_flush = 1'b0; m_done = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input bit vi);
    bit   n_err, n_flush, n_done, kill, empty, lastb;
    int   cur;
    res_t r;
    n_err = 0; n_flush = 0; n_done = 0; kill = 0;
    cur = m_mode;
    empty = 1'b1;
    foreach (m_q[i]) if (m_q[i].due >= cyc) empty = 1'b0;
    while (m_q.size() > 0 && m_q[0].due <= cyc) m_q.delete(0);
    lastb = (m_acc == m_len - 1);
    if (vi) begin
      r.due = cyc + LAT; r.last = lastb;
      m_q.push_back(r);
    end
    if (vi && !outpop) m_cred--;
    else if (!vi && outpop && m_cred < DEPTH) m_cred++;
    case (cur)
      M_IDLE: if (start && !abort) begin
        if (blen == 0) n_err = 1;
        else begin
          m_len = int'(blen); m_acc = 0; m_wb = 0;
          m_mode = reuse ? M_RUN : M_LOAD;
        end
      end
      M_LOAD: if (tvalid) begin
        if (m_wb == W - 1) begin m_mode = M_RUN; m_wb = 0; end
        else if (tlast) begin n_err = 1; m_mode = M_IDLE; m_wb = 0; end
        else m_wb++;
      end
      M_RUN: if (vi) begin
        if (tlast != lastb) begin n_err = 1; kill = 1; end
        else if (lastb) begin m_mode = M_DRAIN; m_acc = 0; end
        else m_acc++;
      end
      M_DRAIN: if (empty) begin m_mode = M_DONE; n_done = 1; end
      default: m_mode = M_IDLE;
    endcase
    if (abort && cur != M_IDLE) begin kill = 1; n_err = 0; end
    if (kill) begin
      m_mode = M_IDLE; m_q.delete(); m_cred = DEPTH;
      n_flush = 1; n_done = 0; m_wb = 0; m_acc = 0;
    end
    m_err = n_err; m_flush = n_flush; m_done = n_done;
  endtask

  // One clock cycle: inputs are already set (at the negedge); compare, advance model.
  task automatic step();
    bit e_tr, e_lw, e_vi, e_vo, e_ol;
    #1;
    if (!rst) model_reset();
    e_tr = (m_mode == M_LOAD) || (m_mode == M_RUN && m_cred > 0);
    e_lw = (m_mode == M_LOAD) && tvalid;
    e_vi = (m_mode == M_RUN) && tvalid && (m_cred > 0);
    e_vo = (m_q.size() > 0) && (m_q[0].due == cyc);
    e_ol = e_vo && m_q[0].last;
    check("tready", tready, e_tr);
    check("loadingWeights", lw_o, e_lw);
    check("validInputs", vi_o, e_vi);
    check("validOutputs", vo_o, e_vo);
    check("outLast", olast, e_ol);
    check("fifoFlush", flush, m_flush);
    check("busy", busy, m_mode != M_IDLE);
    check("done", done, m_done);
    check("error", err, m_err);
    if (lw_o) n_lw++;
    if (vi_o) vi_cyc.push_back(cyc);
    if (vo_o) begin
      if (olast) last_at = vo_cyc.size();
      vo_cyc.push_back(cyc);
    end
    if (done) n_done++;
    if (rst) model_step(e_vi);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clr();
    n_lw = 0; n_done = 0; last_at = -1;
    vi_cyc.delete(); vo_cyc.delete();
  endtask

  task automatic quiet();
    start = 0; abort = 0; tvalid = 0; tlast = 0;
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while (busy && k < maxc) begin step(); k++; end
    n_vec++;
    if (busy) begin
      n_mis++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", maxc);
    end
  endtask

  task automatic launch(input bit ru, input int len);
    start = 1; reuse = ru; blen = LW'(len);
    step();
    start = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_mis = 0; cyc = 0;
    model_reset(); clr();
    rst = 0; reuse = 0; blen = '0; outpop = 0;
    quiet();
    @(negedge clk);
    step(); step();
    checkn("reset_busy", busy, 0);
    checkn("reset_tready", tready, 0);
    rst = 1;
    outpop = 1;
    step(); step();

    // Nominal job with weight load
    clr();
    launch(0, 3);
    tvalid = 1; tlast = 0; step(); tlast = 1; step();
    tlast = 0; step(); step(); tlast = 1; step();
    quiet();
    wait_idle(40);
    checkn("nom_lw_cycles", n_lw, 2);
    checkn("nom_inputs", vi_cyc.size(), 3);
    checkn("nom_results", vo_cyc.size(), 3);
    if (vi_cyc.size() == 3 && vo_cyc.size() == 3)
      for (int i = 0; i < 3; i++) checkn("nom_latency", vo_cyc[i] - vi_cyc[i], 8);
    checkn("nom_last_idx", last_at, 2);
    checkn("nom_done", n_done, 1);

    // Backpressure: four credits, then one pop buys exactly one more beat
    outpop = 1; step(); step();
    clr(); outpop = 0;
    launch(1, 6);
    tvalid = 1;
    repeat (8) begin tlast = (m_acc == 5); step(); end
    checkn("bp_accepts", vi_cyc.size(), 4);
    checkn("bp_tready_low", tready, 0);
    outpop = 1; step(); outpop = 0;
    repeat (6) begin tlast = (m_acc == 5); step(); end
    checkn("bp_after_pop", vi_cyc.size(), 5);
    quiet(); abort = 1; step(); abort = 0;
    checkn("bp_abort_flush", flush, 1);
    outpop = 1; repeat (4) step();

    // Early TLAST in RUN
    launch(1, 3);
    tvalid = 1; tlast = 0; step(); tlast = 1; step();
    quiet();
    checkn("err_run_error", err, 1);
    checkn("err_run_flush", flush, 1);
    checkn("err_run_busy", busy, 0);
    step(); step();
    // TLAST on weight beat 0
    launch(0, 3);
    tvalid = 1; tlast = 1; step();
    quiet();
    checkn("err_load_error", err, 1);
    checkn("err_load_busy", busy, 0);
    step();
    // Zero-length batch
    launch(0, 0);
    checkn("err_zero_error", err, 1);
    checkn("err_zero_busy", busy, 0);
    step();
    checkn("err_zero_busy2", busy, 0);

    // Abort with two beats in flight
    outpop = 0;
    launch(1, 5);
    tvalid = 1; tlast = 0; step(); step();
    quiet(); abort = 1; step(); abort = 0;
    checkn("abort_busy", busy, 0);
    checkn("abort_flush", flush, 1);
    clr();
    repeat (12) step();
    checkn("abort_no_results", vo_cyc.size(), 0);
    checkn("abort_no_done", n_done, 0);
    clr();
    launch(1, 6);
    tvalid = 1; tlast = 0;
    repeat (8) step();
    checkn("abort_credits_restored", vi_cyc.size(), 4);
    quiet(); abort = 1; step(); abort = 0;
    outpop = 1; repeat (4) step();

    // Reuse weights, then async reset in DRAIN
    clr();
    launch(1, 2);
    checkn("reuse_busy", busy, 1);
    checkn("reuse_tready", tready, 1);
    tvalid = 1; tlast = 0; step(); tlast = 1; step();
    quiet(); step(); step();
    checkn("drain_busy", busy, 1);
    checkn("reuse_no_lw", n_lw, 0);
    #2 rst = 0;
    #1;
    checkn("arst_tready", tready, 0);
    checkn("arst_lw", lw_o, 0);
    checkn("arst_vi", vi_o, 0);
    checkn("arst_vo", vo_o, 0);
    checkn("arst_olast", olast, 0);
    checkn("arst_flush", flush, 0);
    checkn("arst_busy", busy, 0);
    checkn("arst_done", done, 0);
    checkn("arst_error", err, 0);
    model_reset(); cyc++;
    @(negedge clk);
    step();
    rst = 1;
    step(); step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      start  = ($urandom_range(0, 7) == 0);
      reuse  = $urandom_range(0, 1);
      blen   = LW'($urandom_range(0, 6));
      abort  = ($urandom_range(0, 99) == 0);
      tvalid = ($urandom_range(0, 3) != 0);
      outpop = ($urandom_range(0, 2) != 0);
      if (m_mode == M_LOAD) tlast = (m_wb == W - 1);
      else tlast = (m_acc == m_len - 1);
      if ($urandom_range(0, 29) == 0) tlast = ~tlast;
      step();
    end
    quiet(); abort = 1; step(); abort = 0; outpop = 1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/job_scheduler.md
JOB_SCHEDULER -- requirements
Module: job_scheduler

Interface
REQ-001 Parameter words, default 2: number of weight beats per weight load.
REQ-002 Parameter latency, default 6+words: cycles from an accepted input beat to its result leaving the array.
REQ-003 Parameter fifoDepth, default 4: entries in the external output FIFO.
REQ-004 Parameter lenWidth, default 16: width of batchLength.
REQ-005 Ports, as name, direction, width, meaning:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  launch a job; sampled in IDLE only.
- reuseWeights  in  1  sampled with start; 1 skips the weight load.
- abort  in  1  cancel the job; honoured in any state.
- batchLength  in  lenWidth  input vectors per job; sampled with start.
- S_AXIS_TVALID  in  1  upstream beat valid.
- S_AXIS_TLAST  in  1  upstream last beat.
- S_AXIS_TREADY  out  1  upstream ready.
- outPop  in  1  output FIFO read handshake (M_AXIS_TVALID & M_AXIS_TREADY).
- loadingWeights  out  1  array weight-capture enable.
- validInputs  out  1  array input valid.
- validOutputs  out  1  output FIFO push.
- outLast  out  1  TLAST to write with the current push.
- fifoFlush  out  1  one-cycle clear of the output FIFO.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle job-complete pulse.
- error  out  1  one-cycle protocol-error pulse.

Function
REQ-006 States: IDLE, LOAD, RUN, DRAIN, DONE, held in a registered state variable.
REQ-007 IDLE: start with batchLength==0 pulses error next cycle and stays in IDLE; otherwise start latches batchLength and goes to RUN if reuseWeights==1, else to LOAD.
REQ-008 LOAD: S_AXIS_TREADY=1 and loadingWeights=S_AXIS_TVALID.
REQ-009 LOAD: the beat counter increments per accepted beat; the beat numbered words-1 moves the block to RUN and clears the counter.
REQ-010 LOAD: TLAST on any beat other than beat words-1 pulses error and returns the block to IDLE.
REQ-011 RUN: S_AXIS_TREADY = (credits>0); an accepted beat (TVALID&TREADY) drives validInputs=1 in the same cycle and increments inCount.
REQ-012 RUN: TLAST is required exactly on beat batchLength-1; a mismatch in either direction pulses error and returns the block to IDLE with a flush (see REQ-018).
REQ-013 RUN: acceptance of beat batchLength-1 moves the block to DRAIN; S_AXIS_TREADY=0 in IDLE, DRAIN and DONE.
REQ-014 A latency-deep valid/last shift register tracks in-flight beats; validOutputs and outLast are its output tap, exactly latency cycles after the matching validInputs.
REQ-015 outLast=1 only with the push of result batchLength-1.
REQ-016 credits: reset value fifoDepth; decrement on an accepted RUN beat; increment on outPop; both in one cycle leaves it unchanged; never above fifoDepth and never below 0; the output FIFO therefore never overflows.
REQ-017 DRAIN moves to DONE once the shift register is empty. DONE pulses done for one cycle, then returns to IDLE; weights are retained for reuseWeights.
REQ-018 abort in any non-IDLE state: next state IDLE, the shift register and counters clear, credits=fifoDepth, and fifoFlush pulses for one cycle; done does not pulse. abort has priority over start and over every other transition.
REQ-019 Widths: inCount is lenWidth bits; the beat counter is $clog2(words+1) bits; credits is $clog2(fifoDepth+1) bits; no counter wraps.

Reset
REQ-020 While rst=0: state=IDLE; counters and shift register zero; credits=fifoDepth; every output 0.
REQ-021 After rst is released, the first state change occurs no earlier than the first rising clk edge.

Verification
REQ-022 The bench shall cover these directed scenarios, with words=2, latency=8, fifoDepth=4 (results and cycles counted from 0):
- Nominal job: start, reuseWeights=0, batchLength=3, 2 weight beats, 3 inputs, outPop always 1 -> 2 loadingWeights cycles; 3 validOutputs pulses each 8 cycles after its input; outLast on result 2; done pulses once.
- Backpressure: batchLength=6, outPop=0 -> S_AXIS_TREADY drops after 4 accepts; 1 outPop pulse -> exactly 1 more beat accepted.
- Protocol errors: TLAST on beat 1 of batchLength=3 -> error pulse, fifoFlush, IDLE; TLAST on weight beat 0 -> error pulse, IDLE; start with batchLength=0 -> error pulse, busy stays 0.
- Abort mid-RUN with 2 beats in flight -> IDLE next cycle; no further validOutputs; credits back to 4; no done pulse.
- Reuse and reset: start with reuseWeights=1 -> goes straight to RUN with loadingWeights never set; rst asserted in DRAIN -> all outputs 0 immediately, asynchronously.
